// File: rtl/cmp8.sv
// Registered, valid-qualified magnitude comparator with one-hot eq/gt/lt flags.
// Optional registered max/min outputs are enabled by defining CMP8_MINMAX_EN.
module cmp8 #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             eq,
    output logic             gt,
    output logic             lt,
`ifdef CMP8_MINMAX_EN
    output logic [WIDTH-1:0] max_o,
    output logic [WIDTH-1:0] min_o,
`endif
    output logic             out_valid
);

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned magnitude compare serves both signedness settings.
    function automatic logic [WIDTH-1:0] order_key(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] k;
        k            = v;
        k[WIDTH-1]   = v[WIDTH-1] ^ SIGNED;
        return k;
    endfunction

    logic [WIDTH-1:0] a_key_s;
    logic [WIDTH-1:0] b_key_s;
    logic             eq_s;
    logic             gt_s;
    logic             lt_s;
`ifdef CMP8_MINMAX_EN
    logic [WIDTH-1:0] max_s;
    logic [WIDTH-1:0] min_s;
`endif

    // Compare of the current operands; no subtraction, so no wrap or overflow.
    always_comb begin
        a_key_s = order_key(a);
        b_key_s = order_key(b);
        eq_s    = 1'b0;
        gt_s    = 1'b0;
        lt_s    = 1'b0;
        if (a_key_s == b_key_s) begin
            eq_s = 1'b1;
        end else if (a_key_s > b_key_s) begin
            gt_s = 1'b1;
        end else begin
            lt_s = 1'b1;
        end
    end

`ifdef CMP8_MINMAX_EN
    // Select max/min from the compare result; on equality both take A.
    always_comb begin
        max_s = a;
        min_s = a;
        if (lt_s) begin
            max_s = b;
            min_s = a;
        end else if (gt_s) begin
            max_s = a;
            min_s = b;
        end else begin
            max_s = a;
            min_s = a;
        end
    end
`endif

    // Result registers: reset wins, a valid sample loads, idle holds the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            out_valid <= 1'b0;
`ifdef CMP8_MINMAX_EN
            max_o     <= {WIDTH{1'b0}};
            min_o     <= {WIDTH{1'b0}};
`endif
        end else if (in_valid) begin
            eq        <= eq_s;
            gt        <= gt_s;
            lt        <= lt_s;
            out_valid <= 1'b1;
`ifdef CMP8_MINMAX_EN
            max_o     <= max_s;
            min_o     <= min_s;
`endif
        end else begin
            eq        <= eq;
            gt        <= gt;
            lt        <= lt;
            out_valid <= 1'b0;
`ifdef CMP8_MINMAX_EN
            max_o     <= max_o;
            min_o     <= min_o;
`endif
        end
    end

endmodule

// File: tb/tb_cmp8.sv
// Directed self-checking bench for cmp8: an unsigned and a signed instance
// share stimulus; max/min checks are compiled in with CMP8_MINMAX_EN.
module tb_cmp8;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_valid;
    logic       eq_u, gt_u, lt_u, ov_u;
    logic       eq_s, gt_s, lt_s, ov_s;
`ifdef CMP8_MINMAX_EN
    logic [7:0] max_u, min_u, max_sg, min_sg;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cmp8 #(.WIDTH(8), .SIGNED(1'b0)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .eq(eq_u), .gt(gt_u), .lt(lt_u),
`ifdef CMP8_MINMAX_EN
        .max_o(max_u), .min_o(min_u),
`endif
        .out_valid(ov_u)
    );

    cmp8 #(.WIDTH(8), .SIGNED(1'b1)) u_dut_signed (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
        .eq(eq_s), .gt(gt_s), .lt(lt_s),
`ifdef CMP8_MINMAX_EN
        .max_o(max_sg), .min_o(min_sg),
`endif
        .out_valid(ov_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs away from the edge, clock once, then settle past the edge.
    task automatic step(input logic [7:0] av, input logic [7:0] bv, input logic v, input logic r);
        @(negedge clk);
        a        = av;
        b        = bv;
        in_valid = v;
        rst      = r;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] va [9] = '{8'd0, 8'd10, 8'd25, 8'd5, 8'd255, 8'd0, 8'd100, 8'd99, 8'd128};
    logic [7:0] vb [9] = '{8'd0, 8'd10, 8'd10, 8'd20, 8'd0, 8'd255, 8'd99, 8'd100, 8'd128};
    logic [2:0] vf [9] = '{3'b100, 3'b100, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b100};

    initial begin
        a = 8'd0; b = 8'd0; in_valid = 1'b0; rst = 1'b1;

        // Reset for two edges, then one idle edge.
        step(8'd0, 8'd0, 1'b0, 1'b1);
        step(8'd0, 8'd0, 1'b0, 1'b1);
        step(8'd0, 8'd0, 1'b0, 1'b0);
        check_val("reset_flags", {29'd0, eq_u, gt_u, lt_u}, 32'd0);
        check_val("reset_valid", {31'd0, ov_u}, 32'd0);
        check_val("reset_flags_signed", {29'd0, eq_s, gt_s, lt_s}, 32'd0);

        // Back-to-back stream of unsigned compares.
        for (int i = 0; i < 9; i++) begin
            step(va[i], vb[i], 1'b1, 1'b0);
            check_val($sformatf("stream_flags_%0d", i), {29'd0, eq_u, gt_u, lt_u}, {29'd0, vf[i]});
            check_val($sformatf("stream_valid_%0d", i), {31'd0, ov_u}, 32'd1);
        end

        // Valid then idle with toggling operands: flags hold, valid drops.
        step(8'd25, 8'd10, 1'b1, 1'b0);
        check_val("hold_first", {29'd0, eq_u, gt_u, lt_u}, 32'b010);
        for (int i = 0; i < 3; i++) begin
            step(8'd3 + 8'(i), 8'd200, 1'b0, 1'b0);
            check_val($sformatf("hold_flags_%0d", i), {29'd0, eq_u, gt_u, lt_u}, 32'b010);
            check_val($sformatf("hold_valid_%0d", i), {31'd0, ov_u}, 32'd0);
        end

        // Reset mid-stream discards the sample presented with it.
        step(8'd5, 8'd20, 1'b1, 1'b0);
        check_val("mid_pre", {29'd0, eq_u, gt_u, lt_u}, 32'b001);
        step(8'd20, 8'd5, 1'b1, 1'b1);
        check_val("mid_rst_flags", {29'd0, eq_u, gt_u, lt_u}, 32'd0);
        check_val("mid_rst_valid", {31'd0, ov_u}, 32'd0);
        step(8'd20, 8'd5, 1'b0, 1'b0);
        check_val("mid_idle_flags", {29'd0, eq_u, gt_u, lt_u}, 32'd0);
        step(8'd20, 8'd5, 1'b1, 1'b0);
        check_val("mid_first_after", {29'd0, eq_u, gt_u, lt_u}, 32'b010);
        check_val("mid_first_valid", {31'd0, ov_u}, 32'd1);

        // Signed vs unsigned ordering of the same bit patterns.
        step(8'h80, 8'h7F, 1'b1, 1'b0);
        check_val("signed_80_7f", {29'd0, eq_s, gt_s, lt_s}, 32'b001);
        check_val("unsigned_80_7f", {29'd0, eq_u, gt_u, lt_u}, 32'b010);
        step(8'hFF, 8'hFE, 1'b1, 1'b0);
        check_val("signed_ff_fe", {29'd0, eq_s, gt_s, lt_s}, 32'b010);
        step(8'hFF, 8'h00, 1'b1, 1'b0);
        check_val("signed_ff_00", {29'd0, eq_s, gt_s, lt_s}, 32'b001);
        check_val("unsigned_ff_00", {29'd0, eq_u, gt_u, lt_u}, 32'b010);
        check_val("signed_valid", {31'd0, ov_s}, 32'd1);

`ifdef CMP8_MINMAX_EN
        step(8'd25, 8'd10, 1'b1, 1'b0);
        check_val("max_25_10", {24'd0, max_u}, 32'd25);
        check_val("min_25_10", {24'd0, min_u}, 32'd10);
        step(8'd128, 8'd128, 1'b1, 1'b0);
        check_val("max_eq", {24'd0, max_u}, 32'd128);
        check_val("min_eq", {24'd0, min_u}, 32'd128);
        step(8'h80, 8'h7F, 1'b1, 1'b0);
        check_val("max_signed", {24'd0, max_sg}, 32'h7F);
        check_val("min_signed", {24'd0, min_sg}, 32'h80);
        step(8'd1, 8'd2, 1'b0, 1'b0);
        check_val("max_hold", {24'd0, max_u}, 32'h80);
        step(8'd1, 8'd2, 1'b0, 1'b1);
        check_val("max_reset", {24'd0, max_u}, 32'd0);
        check_val("min_reset", {24'd0, min_u}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
